mont_mul_arbiter: RTL and testbench
===================================

MONT_MUL_ARBITER -- requirements
Module: mont_mul_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 1024, operand/result width.
REQ-002 SHALL have parameter WDOG_MAX, default 4095, watchdog limit in cycles (used only under REQ-030).
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  in  1 each  requester operation request, level, held until ack.
REQ-006 SHALL have ports a0,b0,n0 / a1,b1,n1  in  DATA_W each  requester operands and modulus.
REQ-007 SHALL have ports ack0/ack1  out  1 each  one-cycle pulse: operands captured.
REQ-008 SHALL have ports done0/done1  out  1 each  one-cycle pulse: result valid.
REQ-009 SHALL have ports err0/err1  out  1 each  one-cycle pulse: operation aborted by watchdog.
REQ-010 SHALL have ports result0/result1  out  DATA_W each  per-requester result register.
REQ-011 SHALL have ports mul_start  out  1, mul_a/mul_b/mul_n  out  DATA_W  shared Montgomery multiplier command.
REQ-012 SHALL have ports mul_done  in  1, mul_result  in  DATA_W  multiplier completion.
REQ-013 SHALL have port mul_clear  out  1  one-cycle pulse resetting the multiplier after abort.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT; all outputs registered.
REQ-015 IDLE: no req -> stay; one req -> grant it; both -> grant requester != last_grant (round-robin).
REQ-016 On grant at edge N: state ISSUE, mul_a/mul_b/mul_n <= granted operands, ackX=1 during cycle N+1, last_grant <= X.
REQ-017 ISSUE: mul_start=1 for exactly one cycle (N+2), state -> WAIT; operands stay stable until next grant.
REQ-018 WAIT: mul_done sampled; mul_done=1 at edge M -> resultX <= mul_result, doneX=1 during cycle M+1, state -> IDLE.
REQ-019 req0/req1 SHALL be ignored in ISSUE and WAIT; mul_done SHALL be ignored outside WAIT.
REQ-020 Minimum req-to-mul_start latency SHALL be 2 cycles; back-to-back grant SHALL be possible in the cycle after return to IDLE.
REQ-021 resultX SHALL hold its value until next doneX for same requester; the other requester's result untouched.
REQ-022 At most one of ack0/ack1/done0/done1/err0/err1 per requester asserted per cycle; ack0 and ack1 never together.
REQ-023 mul_done coincident with mul_start cycle SHALL be ignored (not yet WAIT).

Reset
REQ-024 reset=1 at any edge SHALL force state IDLE regardless of current state, aborting any operation without done/err.
REQ-025 Reset values: ack*, done*, err*, mul_start, mul_clear = 0; result*, mul_a, mul_b, mul_n = 0; last_grant = 1 (requester 0 wins first tie); watchdog counter = 0.
REQ-026 Requests held through reset SHALL be arbitrated normally on the first edge after reset deasserts.

Configuration
REQ-030 With MONT_ARB_WATCHDOG_EN defined: 12-bit+ counter cleared on entering WAIT, increments each WAIT cycle; reaching WDOG_MAX without mul_done -> errX pulse, mul_clear pulse (same cycle), resultX unchanged, state -> IDLE.
REQ-031 mul_done in the same cycle the counter reaches WDOG_MAX SHALL win (done, no err).
REQ-032 Without MONT_ARB_WATCHDOG_EN: no counter, WAIT unbounded, err0/err1/mul_clear tied 0; ports remain present.

Verification
REQ-040 req0 only, a0=3,b0=5,n0=7, model returns 8 after 10 cycles -> ack0 at N+1, mul_start at N+2, mul_a=3, done0 one cycle after mul_done, result0=8.
REQ-041 req0 and req1 asserted same edge after reset -> ack0 first; after done0, ack1 next; repeat both -> grant order 0,1,0,1.
REQ-042 req1 asserted during WAIT of requester 0 -> no ack1 until cycle after done0; result0 unchanged after done1.
REQ-043 reset pulsed 1 cycle in WAIT, mul_done later -> no done0/done1, state IDLE, all outputs 0 next cycle.
REQ-044 Watchdog build, model never asserts mul_done -> err0 and mul_clear pulse after WDOG_MAX WAIT cycles, result0 unchanged; non-watchdog build same stimulus -> FSM stays in WAIT, err0=0.
REQ-045 mul_done asserted during ISSUE cycle and again later -> only the later one produces done0.

Source files
------------

// File: rtl/mont_mul_arbiter.sv
// mont_mul_arbiter: round-robin arbiter that shares one Montgomery multiplier
// between two requesters. Per-requester handshakes are ack (operands
// captured), done (result valid) and err (operation aborted).
// Optional watchdog: define MONT_ARB_WATCHDOG_EN to bound the WAIT state.
// Without the macro, err0/err1/mul_clear are tied low and WAIT is unbounded.
module mont_mul_arbiter #(
  parameter int DATA_W   = 1024,
  parameter int WDOG_MAX = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] n0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  input  logic [DATA_W-1:0] n1,
  output logic              ack0,
  output logic              ack1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] result0,
  output logic [DATA_W-1:0] result1,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  output logic [DATA_W-1:0] mul_n,
  input  logic              mul_done,
  input  logic [DATA_W-1:0] mul_result,
  output logic              mul_clear
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_reg, state_next;
  logic              last_grant_reg, last_grant_next;
  logic [1:0]        ack_reg, ack_next;
  logic [1:0]        done_reg, done_next;
  logic              mul_start_reg, mul_start_next;
  logic [DATA_W-1:0] mul_a_reg, mul_b_reg, mul_n_reg;
  logic              load_ops;
  logic              grant_sel;
  logic [1:0]        result_we;

`ifdef MONT_ARB_WATCHDOG_EN
  localparam int WDOG_W = ($clog2(WDOG_MAX + 1) > 12) ? $clog2(WDOG_MAX + 1) : 12;
  logic [WDOG_W-1:0] wdog_cnt_reg;
  logic              wdog_clr;
  logic              wdog_inc;
  logic [1:0]        err_reg, err_next;
  logic              mul_clear_reg, mul_clear_next;
`endif

  // Next-state, grant decision and registered-output pulses.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    ack_next        = 2'b00;
    done_next       = 2'b00;
    mul_start_next  = 1'b0;
    load_ops        = 1'b0;
    grant_sel       = 1'b0;
    result_we       = 2'b00;
`ifdef MONT_ARB_WATCHDOG_EN
    err_next        = 2'b00;
    mul_clear_next  = 1'b0;
    wdog_clr        = 1'b0;
    wdog_inc        = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (req0 && req1) begin
          grant_sel = ~last_grant_reg;
          load_ops  = 1'b1;
        end else if (req0) begin
          grant_sel = 1'b0;
          load_ops  = 1'b1;
        end else if (req1) begin
          grant_sel = 1'b1;
          load_ops  = 1'b1;
        end
        if (load_ops) begin
          ack_next[grant_sel] = 1'b1;
          last_grant_next     = grant_sel;
          state_next          = ISSUE;
        end
      end
      ISSUE: begin
        // ISSUE spans the ack cycle and the mul_start cycle, so a mul_done
        // seen while mul_start is high is never taken as completion.
        if (!mul_start_reg) begin
          mul_start_next = 1'b1;
        end else begin
          state_next = WAIT;
`ifdef MONT_ARB_WATCHDOG_EN
          wdog_clr   = 1'b1;
`endif
        end
      end
      WAIT: begin
        // last_grant doubles as the owner of the in-flight operation.
        if (mul_done) begin
          result_we[last_grant_reg] = 1'b1;
          done_next[last_grant_reg] = 1'b1;
          state_next                = IDLE;
        end
`ifdef MONT_ARB_WATCHDOG_EN
        else if (wdog_cnt_reg == WDOG_W'(WDOG_MAX - 1)) begin
          err_next[last_grant_reg] = 1'b1;
          mul_clear_next           = 1'b1;
          state_next               = IDLE;
        end else begin
          wdog_inc = 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // State, grant history and handshake pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      ack_reg        <= 2'b00;
      done_reg       <= 2'b00;
      mul_start_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      ack_reg        <= ack_next;
      done_reg       <= done_next;
      mul_start_reg  <= mul_start_next;
    end
  end

  // Multiplier command operands: loaded on grant, held until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a_reg <= '0;
      mul_b_reg <= '0;
      mul_n_reg <= '0;
    end else if (load_ops) begin
      mul_a_reg <= grant_sel ? a1 : a0;
      mul_b_reg <= grant_sel ? b1 : b0;
      mul_n_reg <= grant_sel ? n1 : n0;
    end
  end

  // Per-requester result registers; only the owner's register is written.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_res
      logic [DATA_W-1:0] res_reg;
      // Capture the multiplier result on completion for this requester.
      always_ff @(posedge clk) begin
        if (reset) begin
          res_reg <= '0;
        end else if (result_we[gi]) begin
          res_reg <= mul_result;
        end
      end
    end
  endgenerate

`ifdef MONT_ARB_WATCHDOG_EN
  // Watchdog counter and abort pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt_reg  <= '0;
      err_reg       <= 2'b00;
      mul_clear_reg <= 1'b0;
    end else begin
      err_reg       <= err_next;
      mul_clear_reg <= mul_clear_next;
      if (wdog_clr) begin
        wdog_cnt_reg <= '0;
      end else if (wdog_inc) begin
        wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
      end
    end
  end

  assign err0      = err_reg[0];
  assign err1      = err_reg[1];
  assign mul_clear = mul_clear_reg;
`else
  assign err0      = 1'b0;
  assign err1      = 1'b0;
  assign mul_clear = 1'b0;
`endif

  assign ack0      = ack_reg[0];
  assign ack1      = ack_reg[1];
  assign done0     = done_reg[0];
  assign done1     = done_reg[1];
  assign result0   = g_res[0].res_reg;
  assign result1   = g_res[1].res_reg;
  assign mul_start = mul_start_reg;
  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;
  assign mul_n     = mul_n_reg;

endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Testbench for mont_mul_arbiter: table of full transactions plus directed
// sequences for queued requests, reset abort, early mul_done and watchdog.
module tb_mont_mul_arbiter;
  localparam int DW   = 16;
  localparam int WDOG = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [DW-1:0] a0, b0, n0, a1, b1, n1;
  logic          ack0, ack1, done0, done1, err0, err1;
  logic [DW-1:0] result0, result1;
  logic          mul_start, mul_clear, mul_done;
  logic [DW-1:0] mul_a, mul_b, mul_n, mul_result;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_res [2];

  mont_mul_arbiter #(.DATA_W(DW), .WDOG_MAX(WDOG)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .n0(n0), .a1(a1), .b1(b1), .n1(n1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .result0(result0), .result1(result1),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_n(mul_n),
    .mul_done(mul_done), .mul_result(mul_result), .mul_clear(mul_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          r0, r1;
    logic [DW-1:0] a0, b0, n0, a1, b1, n1;
    int            g;
    logic [DW-1:0] ea, eb, en;
    int            dly;
    logic [DW-1:0] res;
  } vec_t;

  vec_t vecs [7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_pulses"}, {ack0, ack1, done0, done1, err0, err1, mul_start, mul_clear}, 0);
    chk({name, "_ops"}, {mul_a, mul_b, mul_n}, 0);
    chk({name, "_res"}, {result0, result1}, 0);
  endtask

  // Request, wait for ack (one cycle expected), release the granted request.
  task automatic grant(input int g, output bit ok);
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (ack0 || ack1) begin
        ok = 1;
        chk("ack_latency", i, 0);
        break;
      end
    end
    chk("ack_seen", ok, 1);
    if (ok) begin
      chk("ack0", ack0, g == 0);
      chk("ack1", ack1, g == 1);
      if (g == 0) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  // Apply mul_done with a result and check the completion for requester g.
  task automatic complete(input int g, input logic [DW-1:0] res);
    mul_done = 1'b1;
    mul_result = res;
    tick;
    mul_done = 1'b0;
    chk("done0", done0, g == 0);
    chk("done1", done1, g == 1);
    chk("err", {err0, err1}, 0);
    exp_res[g] = res;
    chk("result0", result0, exp_res[0]);
    chk("result1", result1, exp_res[1]);
    $display("txn: requester %0d result %0h", g, res);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    req0 = v.r0; req1 = v.r1;
    a0 = v.a0; b0 = v.b0; n0 = v.n0;
    a1 = v.a1; b1 = v.b1; n1 = v.n1;
    grant(v.g, ok);
    if (!ok) return;
    chk("done_pulse_width", {done0, done1}, 0);
    chk("mul_a", mul_a, v.ea);
    chk("mul_b", mul_b, v.eb);
    chk("mul_n", mul_n, v.en);
    chk("mul_start_early", mul_start, 0);
    tick;
    chk("mul_start", mul_start, 1);
    chk("ack_width", {ack0, ack1}, 0);
    tick;
    chk("mul_start_width", mul_start, 0);
    for (int i = 0; i < v.dly; i++) begin
      tick;
      chk("early_done", {done0, done1}, 0);
    end
    complete(v.g, v.res);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    bit seen;
    int cnt;
    //          r0 r1 a0      b0      n0      a1      b1      n1      g ea      eb      en      dly res
    vecs[0] = '{1, 0, 16'd3,  16'd5,  16'd7,  16'd0,  16'd0,  16'd0,  0, 16'd3,  16'd5,  16'd7,  10, 16'd8};
    vecs[1] = '{0, 1, 16'd1,  16'd2,  16'd3,  16'd11, 16'd13, 16'd17, 1, 16'd11, 16'd13, 16'd17, 3, 16'h1234};
    vecs[2] = '{1, 1, 16'h21, 16'h22, 16'h23, 16'h31, 16'h32, 16'h33, 0, 16'h21, 16'h22, 16'h23, 0, 16'h55};
    vecs[3] = '{1, 1, 16'h21, 16'h22, 16'h23, 16'h31, 16'h32, 16'h33, 1, 16'h31, 16'h32, 16'h33, 1, 16'h66};
    vecs[4] = '{1, 1, 16'h41, 16'h42, 16'h43, 16'h51, 16'h52, 16'h53, 0, 16'h41, 16'h42, 16'h43, 2, 16'h77};
    vecs[5] = '{1, 1, 16'h41, 16'h42, 16'h43, 16'h51, 16'h52, 16'h53, 1, 16'h51, 16'h52, 16'h53, 0, 16'h88};
    vecs[6] = '{1, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'h0, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 16'hFFFF};

    exp_res[0] = '0; exp_res[1] = '0;
    reset = 1'b1; req0 = 0; req1 = 0; mul_done = 0; mul_result = '0;
    a0 = '0; b0 = '0; n0 = '0; a1 = '0; b1 = '0; n1 = '0;
    repeat (3) tick;
    chk_all_zero("reset_state");
    reset = 1'b0;
    tick;
    chk_all_zero("idle_state");

    // Table-driven transactions, including round-robin order 0,1,0,1.
    foreach (vecs[i]) run_vec(vecs[i]);
    req0 = 0; req1 = 0;
    tick; tick;
    chk("idle_after_table", {ack0, ack1, mul_start}, 0);

    // Request 1 arriving while requester 0 is in WAIT is held off.
    req0 = 1; a0 = 16'h40; b0 = 16'h41; n0 = 16'h42;
    grant(0, ok);
    tick; tick;
    req1 = 1; a1 = 16'h50; b1 = 16'h51; n1 = 16'h52;
    seen = 0;
    for (int i = 0; i < 5; i++) begin tick; seen |= ack1; end
    chk("ack1_held_off", seen, 0);
    complete(0, 16'h4444);
    chk("ack1_with_done0", ack1, 0);
    tick;
    chk("ack1_after_done0", ack1, 1);
    chk("mul_a_req1", mul_a, 16'h50);
    req1 = 0;
    tick; tick;
    complete(1, 16'h5555);

    // mul_done during the mul_start cycle is ignored.
    req0 = 1; a0 = 16'h7;
    grant(0, ok);
    tick;
    chk("mul_start_c", mul_start, 1);
    mul_done = 1; mul_result = 16'hAAAA;
    tick;
    mul_done = 0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin seen |= done0 | done1; tick; end
    seen |= done0 | done1;
    chk("early_mul_done_ignored", seen, 0);
    chk("result0_kept", result0, exp_res[0]);
    complete(0, 16'hBBBB);

`ifdef MONT_ARB_WATCHDOG_EN
    // Watchdog abort after WDOG WAIT cycles with no mul_done.
    req0 = 1; a0 = 16'h9;
    grant(0, ok);
    tick; tick;
    cnt = 0;
    for (int i = 1; i <= 3 * WDOG; i++) begin
      tick;
      if (err0) begin cnt = i; break; end
    end
    chk("wdog_cycles", cnt, WDOG);
    chk("wdog_mul_clear", mul_clear, 1);
    chk("wdog_no_done", {done0, done1, err1}, 0);
    chk("wdog_result0", result0, exp_res[0]);
    $display("txn: requester 0 aborted after %0d cycles", cnt);
    tick;
    chk("wdog_pulse_width", {err0, mul_clear}, 0);
    // mul_done on the same edge the counter expires wins.
    req0 = 1;
    grant(0, ok);
    tick; tick;
    repeat (WDOG - 1) tick;
    complete(0, 16'hCCCC);
    chk("wdog_tie_no_clear", mul_clear, 0);
`else
    // Without the watchdog, WAIT is held indefinitely.
    req0 = 1; a0 = 16'h9;
    grant(0, ok);
    tick; tick;
    seen = 0;
    for (int i = 0; i < 2 * WDOG; i++) begin tick; seen |= err0 | err1 | mul_clear | done0; end
    chk("no_wdog_no_err", seen, 0);
    complete(0, 16'hCCCC);
`endif

    // Reset in WAIT aborts silently; later mul_done is ignored.
    req0 = 1; a0 = 16'h11;
    grant(0, ok);
    tick; tick; tick;
    reset = 1;
    tick;
    reset = 0;
    exp_res[0] = '0; exp_res[1] = '0;
    chk_all_zero("after_reset");
    mul_done = 1; mul_result = 16'h9999;
    tick;
    mul_done = 0;
    chk("post_reset_done", {done0, done1, err0, err1}, 0);
    chk("post_reset_result0", result0, 0);
    // Requests held through reset are arbitrated on the first edge after it.
    req0 = 1; req1 = 1; a0 = 16'h12; a1 = 16'h13;
    reset = 1;
    tick;
    reset = 0;
    tick;
    chk("first_tie_ack0", ack0, 1);
    chk("first_tie_ack1", ack1, 0);
    chk("first_tie_mul_a", mul_a, 16'h12);
    req0 = 0; req1 = 0;
    tick; tick;
    complete(0, 16'h1357);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
